// File: rtl/led_step_gen_if.sv
// Control/observation bundle for led_step_gen: switches and button in,
// advance pulse and debounce state out.
interface led_step_gen_if;
    logic [2:0] i_sw;
    logic       i_step;
    logic       o_valid;
    logic [1:0] o_state;

    modport master (
        output i_sw,
        output i_step,
        input  o_valid,
        input  o_state
    );

    modport slave (
        input  i_sw,
        input  i_step,
        output o_valid,
        output o_state
    );
endinterface

// File: rtl/led_step_gen.sv
// Advance-pulse generator for the rotating LED register: periodic pulses in
// run mode, one pulse per debounced button press in step mode.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | button released and accepted, waiting for a press
// PRESS_WAIT   | button seen high, counting stable-high cycles
// PRESSED      | press accepted, single cycle that requests the pulse
// RELEASE_WAIT | waiting for the button to be low for a full debounce time
module led_step_gen #(
    parameter int                    NB_COUNTER      = 32,
    parameter logic [NB_COUNTER-1:0] LIMIT_0         = NB_COUNTER'(2**23 - 1),
    parameter logic [NB_COUNTER-1:0] LIMIT_1         = NB_COUNTER'(2**24 - 1),
    parameter logic [NB_COUNTER-1:0] LIMIT_2         = NB_COUNTER'(2**25 - 1),
    parameter logic [NB_COUNTER-1:0] LIMIT_3         = NB_COUNTER'(2**26 - 1),
    parameter int                    NB_DEBOUNCE     = 20,
    parameter int                    DEBOUNCE_CYCLES = 500000
) (
    input  logic          clock,
    input  logic          i_reset,
    led_step_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [NB_DEBOUNCE-1:0] DB_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

    logic [NB_COUNTER-1:0]  count;
    logic [NB_COUNTER-1:0]  limit_sel;
    logic                   run_hit;
    logic                   step_meta;
    logic                   s_step;
    logic [1:0]             state;
    logic [NB_DEBOUNCE-1:0] db_count;

    // Rate select: pick the period limit from the switch pair.
    always_comb begin
        limit_sel = LIMIT_0;
        case (bus.i_sw[2:1])
            2'd0:    limit_sel = LIMIT_0;
            2'd1:    limit_sel = LIMIT_1;
            2'd2:    limit_sel = LIMIT_2;
            default: limit_sel = LIMIT_3;
        endcase
    end

    // >= rather than == so a drop to a smaller limit wraps on the next edge.
    assign run_hit = bus.i_sw[0] && (count >= limit_sel);

    // Period counter: wraps at the selected limit, held at zero when stopped.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (!bus.i_sw[0]) begin
            count <= '0;
        end else if (count >= limit_sel) begin
            count <= '0;
        end else begin
            count <= count + NB_COUNTER'(1);
        end
    end

    // Two-flop synchronizer for the raw push button.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            step_meta <= 1'b0;
            s_step    <= 1'b0;
        end else begin
            step_meta <= bus.i_step;
            s_step    <= step_meta;
        end
    end

    // Debounce FSM: a press must be stable for the full count, and so must
    // the release before another press is considered.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            db_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    db_count <= '0;
                    if (s_step) begin
                        state <= ST_PRESS_WAIT;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s_step) begin
                        state <= ST_IDLE;
                    end else if (db_count == DB_LAST) begin
                        state    <= ST_PRESSED;
                        db_count <= '0;
                    end else begin
                        db_count <= db_count + NB_DEBOUNCE'(1);
                    end
                end
                ST_PRESSED: begin
                    state    <= ST_RELEASE_WAIT;
                    db_count <= '0;
                end
                default: begin
                    if (s_step) begin
                        db_count <= '0;
                    end else if (db_count == DB_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        db_count <= db_count + NB_DEBOUNCE'(1);
                    end
                end
            endcase
        end
    end

    // Registered advance pulse; button presses only count in step mode.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= run_hit || ((state == ST_PRESSED) && !bus.i_sw[0]);
        end
    end

    assign bus.o_state = state;

endmodule

// File: tb/tb_led_step_gen.sv
// Directed bench for led_step_gen with small limits (3/7/15/31) and a
// debounce time of 4 cycles.
module tb_led_step_gen;

    typedef struct {
        logic [2:0] sw;
        logic       step;
        logic       exp_valid;
        logic [1:0] exp_state;
    } vec_t;

    logic clock;
    logic i_reset;
    int   tests;
    int   failed;
    vec_t vecs [32];

    led_step_gen_if bus ();

    led_step_gen #(
        .NB_COUNTER      (32),
        .LIMIT_0         (32'd3),
        .LIMIT_1         (32'd7),
        .LIMIT_2         (32'd15),
        .LIMIT_3         (32'd31),
        .NB_DEBOUNCE     (20),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        i_reset    = 1'b1;
        bus.i_sw   = 3'b000;
        bus.i_step = 1'b0;

        // Vector table: inputs before edge i, outputs after edge i.
        for (int i = 0; i < 32; i++) begin
            vecs[i].exp_valid = 1'b0;
            vecs[i].exp_state = 2'd0;
            if (i < 12) begin
                vecs[i].sw        = 3'b001;
                vecs[i].step      = 1'b0;
                vecs[i].exp_valid = ((i % 4) == 3);
            end else if (i == 12) begin
                vecs[i].sw   = 3'b000;
                vecs[i].step = 1'b0;
            end else if (i < 24) begin
                vecs[i].sw        = 3'b000;
                vecs[i].step      = 1'b1;
                vecs[i].exp_valid = (i == 20);
                if (i < 15)       vecs[i].exp_state = 2'd0;
                else if (i < 19)  vecs[i].exp_state = 2'd1;
                else if (i == 19) vecs[i].exp_state = 2'd2;
                else              vecs[i].exp_state = 2'd3;
            end else begin
                vecs[i].sw        = 3'b000;
                vecs[i].step      = 1'b0;
                vecs[i].exp_state = (i < 29) ? 2'd3 : 2'd0;
            end
        end

        // Held in reset across a couple of edges.
        cyc();
        cyc();
        check("reset_valid", bus.o_valid, 0);
        check("reset_state", bus.o_state, 0);
        i_reset = 1'b0;

        // Periodic run, then a clean step press and release.
        for (int i = 0; i < 32; i++) begin
            bus.i_sw   = vecs[i].sw;
            bus.i_step = vecs[i].step;
            cyc();
            check($sformatf("vec%0d_valid", i), bus.o_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_state", i), bus.o_state, vecs[i].exp_state);
        end

        // Rate change from limit 31 down to 3 at count 20.
        bus.i_sw = 3'b111;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("rate31_quiet", bus.o_valid, 0);
        end
        bus.i_sw = 3'b001;
        cyc();
        check("rate_drop_wrap", bus.o_valid, 1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("rate_drop_period4", bus.o_valid, ((i % 4) == 3));
        end
        bus.i_sw = 3'b000;
        cyc();
        check("disable_valid", bus.o_valid, 0);
        bus.i_sw = 3'b011;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("period8", bus.o_valid, ((i % 8) == 7));
        end
        bus.i_sw = 3'b000;
        cyc();
        bus.i_sw = 3'b101;
        for (int i = 0; i < 32; i++) begin
            cyc();
            check("period16", bus.o_valid, ((i % 16) == 15));
        end
        bus.i_sw = 3'b000;
        cyc();

        // Bouncing press: 1,1,0,1,1,1,0 then stable high from index 7.
        begin
            logic [6:0] pat;
            pat = 7'b0111011;
            for (int i = 0; i < 25; i++) begin
                bus.i_step = (i < 7) ? pat[i] : 1'b1;
                cyc();
                check("bounce_press_valid", bus.o_valid, (i == 14));
            end
        end
        check("bounce_held_state", bus.o_state, 3);
        // Bouncing release: 0,0,1 then stable low.
        for (int i = 0; i < 20; i++) begin
            bus.i_step = (i == 2);
            cyc();
            check("bounce_release_valid", bus.o_valid, 0);
        end
        check("bounce_release_state", bus.o_state, 0);

        // Press during run mode: FSM walks, no extra pulse.
        bus.i_sw = 3'b001;
        for (int i = 0; i < 24; i++) begin
            bus.i_step = (i >= 2);
            cyc();
            check("run_press_valid", bus.o_valid, ((i % 4) == 3));
            if (i == 8) check("run_press_state2", bus.o_state, 2);
            if (i == 9) check("run_press_state3", bus.o_state, 3);
        end
        bus.i_sw   = 3'b000;
        bus.i_step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("run_press_after_valid", bus.o_valid, 0);
        end
        check("run_press_after_state", bus.o_state, 0);

        // Asynchronous reset mid-cycle while a run pulse is showing.
        bus.i_sw = 3'b001;
        for (int i = 0; i < 4; i++) cyc();
        check("pre_reset_pulse", bus.o_valid, 1);
        #2;
        i_reset = 1'b1;
        #1;
        check("async_reset_valid", bus.o_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("in_reset_valid", bus.o_valid, 0);
        end
        i_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("post_reset_run", bus.o_valid, ((i % 4) == 3));
        end
        bus.i_sw = 3'b000;
        cyc();

        // Reset while in PRESS_WAIT, button kept held throughout.
        bus.i_step = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("predeb_valid", bus.o_valid, 0);
        end
        check("predeb_state", bus.o_state, 1);
        #2;
        i_reset = 1'b1;
        #1;
        check("middeb_reset_state", bus.o_state, 0);
        check("middeb_reset_valid", bus.o_valid, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("middeb_hold_state", bus.o_state, 0);
        end
        i_reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("restart_valid", bus.o_valid, (i == 7));
            if (i == 2) check("restart_state1", bus.o_state, 1);
            if (i == 6) check("restart_state2", bus.o_state, 2);
        end
        bus.i_step = 1'b0;
        for (int i = 0; i < 8; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
